// File: rtl/game_pkg.sv
// Shared types, enums and helpers for the 2048 game controller.
package game_pkg;

  localparam int unsigned CELL_W      = 4;
  localparam int unsigned LFSR_W      = 16;
  localparam int unsigned WIN_EXP_DEF = 11;

  typedef logic [CELL_W-1:0] cell_t;
  typedef cell_t [15:0]      board_t;
  typedef cell_t [3:0]       line_t;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_MOVE,
    ST_SPAWN,
    ST_CHECK,
    ST_OVER
  } state_e;

  typedef enum logic [1:0] {
    DIR_UP,
    DIR_DOWN,
    DIR_LEFT,
    DIR_RIGHT
  } dir_e;

  // Exponent increment that sticks at the largest representable tile.
  function automatic cell_t sat_inc(cell_t c);
    return (c == cell_t'(15)) ? c : c + cell_t'(1);
  endfunction

  // Board index of position p in line k; position 0 sits on the move's leading edge.
  function automatic logic [3:0] line_idx(dir_e dir, logic [1:0] k, logic [1:0] p);
    logic [3:0] idx;
    case (dir)
      DIR_UP:   idx = {p, k};
      DIR_DOWN: idx = {2'd3 - p, k};
      DIR_LEFT: idx = {k, p};
      default:  idx = {k, 2'd3 - p};
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/line_merge.sv
// Combinational slide-and-merge of one 4-cell line toward position 0.
module line_merge
  import game_pkg::*;
(
  input  line_t line_i,
  output line_t line_o,
  output logic  changed_o
);

  line_t packed_l;
  line_t merged_l;

  // Move all nonzero cells toward position 0, keeping their order.
  function automatic line_t compress(line_t l);
    line_t      r;
    logic [1:0] wr;
    r  = '0;
    wr = '0;
    for (int i = 0; i < 4; i++) begin
      if (l[i] != '0) begin
        r[wr] = l[i];
        wr    = wr + 2'd1;
      end
    end
    return r;
  endfunction

  // Compress, merge equal neighbours once each from position 0, compress again.
  always_comb begin
    packed_l = compress(line_i);
    merged_l = packed_l;
    for (int i = 0; i < 3; i++) begin
      if (merged_l[i] != '0 && merged_l[i] == merged_l[i+1]) begin
        merged_l[i]   = sat_inc(merged_l[i]);
        merged_l[i+1] = '0;
      end
    end
    line_o    = compress(merged_l);
    changed_o = (line_o != line_i);
  end

endmodule

// File: rtl/game_ctrl.sv
// 2048 game controller: board state, move sequencing, tile spawning, win/lose detection.
module game_ctrl
  import game_pkg::*;
#(
  parameter int unsigned       WIN_EXP   = WIN_EXP_DEF,
  parameter logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   mv_up,
  input  logic   mv_down,
  input  logic   mv_left,
  input  logic   mv_right,
  input  logic   new_game,
  input  logic   load,
  input  board_t load_states,
  output board_t states,
  output logic   win,
  output logic   lose,
  output logic   busy
);

  localparam cell_t WIN_CELL = cell_t'(WIN_EXP);

  state_e            state_q, state_d;
  dir_e              dir_q, dir_d;
  logic [1:0]        line_q, line_d;
  logic              init_cnt_q, init_cnt_d;
  logic              changed_q, changed_d;
  board_t            board_q, board_d;
  logic              win_q, win_d;
  logic              lose_q, lose_d;
  logic              busy_q, busy_d;
  logic [LFSR_W-1:0] lfsr_q, lfsr_d;

  line_t      line_in;
  line_t      line_out;
  logic       line_changed;
  logic       spawn_ok;
  logic [3:0] spawn_idx;
  cell_t      spawn_val;
  logic       any_win;
  logic       any_empty;
  logic       any_pair;
  logic       lose_c;

  // Gather the line currently being processed.
  always_comb begin
    for (int p = 0; p < 4; p++) begin
      line_in[p] = board_q[line_idx(dir_q, line_q, 2'(p))];
    end
  end

  line_merge u_line_merge (
    .line_i    (line_in),
    .line_o    (line_out),
    .changed_o (line_changed)
  );

  // First empty cell scanning upward from lfsr[3:0], wrapping 15 -> 0.
  always_comb begin
    logic [3:0] idx;
    spawn_ok  = 1'b0;
    spawn_idx = '0;
    for (int i = 15; i >= 0; i--) begin
      idx = lfsr_q[3:0] + 4'(i);
      if (board_q[idx] == '0) begin
        spawn_ok  = 1'b1;
        spawn_idx = idx;
      end
    end
  end

  assign spawn_val = (lfsr_q[7:4] == 4'd0) ? cell_t'(2) : cell_t'(1);

  // Board-wide win tile, empty cell and adjacent-equal-pair detection.
  always_comb begin
    any_win   = 1'b0;
    any_empty = 1'b0;
    any_pair  = 1'b0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (board_q[4'(r*4+c)] >= WIN_CELL) any_win = 1'b1;
        if (board_q[4'(r*4+c)] == '0) any_empty = 1'b1;
        if (c < 3 && board_q[4'(r*4+c)] == board_q[4'(r*4+c+1)]) any_pair = 1'b1;
        if (r < 3 && board_q[4'(r*4+c)] == board_q[4'(r*4+c+4)]) any_pair = 1'b1;
      end
    end
    lose_c = !any_win && !any_empty && !any_pair;
  end

  // Next-state and datapath updates.
  always_comb begin
    state_d    = state_q;
    dir_d      = dir_q;
    line_d     = line_q;
    init_cnt_d = init_cnt_q;
    changed_d  = changed_q;
    board_d    = board_q;
    win_d      = win_q;
    lose_d     = lose_q;
    lfsr_d     = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

    case (state_q)
      ST_INIT: begin
        if (spawn_ok) board_d[spawn_idx] = spawn_val;
        init_cnt_d = ~init_cnt_q;
        if (init_cnt_q) state_d = ST_IDLE;
      end
      ST_IDLE, ST_OVER: begin
        if (new_game) begin
          board_d    = '0;
          win_d      = 1'b0;
          lose_d     = 1'b0;
          init_cnt_d = 1'b0;
          state_d    = ST_INIT;
        end else if (load) begin
          board_d = load_states;
          win_d   = 1'b0;
          lose_d  = 1'b0;
          state_d = ST_CHECK;
        end else if (state_q == ST_IDLE && (mv_up || mv_down || mv_left || mv_right)) begin
          if (mv_up)        dir_d = DIR_UP;
          else if (mv_down) dir_d = DIR_DOWN;
          else if (mv_left) dir_d = DIR_LEFT;
          else              dir_d = DIR_RIGHT;
          line_d    = 2'd0;
          changed_d = 1'b0;
          state_d   = ST_MOVE;
        end
      end
      ST_MOVE: begin
        for (int p = 0; p < 4; p++) begin
          board_d[line_idx(dir_q, line_q, 2'(p))] = line_out[p];
        end
        changed_d = changed_q || line_changed;
        line_d    = line_q + 2'd1;
        if (line_q == 2'd3) state_d = ST_SPAWN;
      end
      ST_SPAWN: begin
        if (changed_q && spawn_ok) board_d[spawn_idx] = spawn_val;
        state_d = ST_CHECK;
      end
      ST_CHECK: begin
        win_d   = any_win;
        lose_d  = lose_c;
        state_d = (any_win || lose_c) ? ST_OVER : ST_IDLE;
      end
      default: state_d = ST_INIT;
    endcase

    busy_d = (state_d != ST_IDLE) && (state_d != ST_OVER);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_INIT;
      dir_q      <= DIR_UP;
      line_q     <= '0;
      init_cnt_q <= 1'b0;
      changed_q  <= 1'b0;
      board_q    <= '0;
      win_q      <= 1'b0;
      lose_q     <= 1'b0;
      busy_q     <= 1'b1;
      lfsr_q     <= LFSR_SEED;
    end else begin
      state_q    <= state_d;
      dir_q      <= dir_d;
      line_q     <= line_d;
      init_cnt_q <= init_cnt_d;
      changed_q  <= changed_d;
      board_q    <= board_d;
      win_q      <= win_d;
      lose_q     <= lose_d;
      busy_q     <= busy_d;
      lfsr_q     <= lfsr_d;
    end
  end

  assign states = board_q;
  assign win    = win_q;
  assign lose   = lose_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Self-checking bench for game_ctrl against a list-based game model.
module tb_game_ctrl;
  import game_pkg::*;

  localparam logic [15:0] SEED = 16'hACE1;
  localparam int          WIN  = 11;

  logic   clk = 1'b0;
  logic   reset = 1'b0;
  logic   mv_up = 1'b0, mv_down = 1'b0, mv_left = 1'b0, mv_right = 1'b0;
  logic   new_game = 1'b0, load = 1'b0;
  board_t load_states = '0;
  board_t states;
  logic   win, lose, busy;

  game_ctrl #(.WIN_EXP(WIN), .LFSR_SEED(SEED)) dut (
    .clk(clk), .reset(reset),
    .mv_up(mv_up), .mv_down(mv_down), .mv_left(mv_left), .mv_right(mv_right),
    .new_game(new_game), .load(load), .load_states(load_states),
    .states(states), .win(win), .lose(lose), .busy(busy)
  );

  always #5 clk = ~clk;

  // Model state
  logic [3:0]  mb [16];
  bit          m_win, m_lose, m_over, m_changed;
  logic [15:0] m_lfsr;
  int          n_cmp = 0;
  int          n_bad = 0;

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {l[14:0], ^(l & 16'hB400)};
  endfunction

  function automatic logic [15:0] lfsr_adv(input logic [15:0] l, input int n);
    logic [15:0] r = l;
    for (int i = 0; i < n; i++) r = lfsr_step(r);
    return r;
  endfunction

  function automatic board_t pack_model();
    board_t b;
    for (int i = 0; i < 16; i++) b[i] = mb[i];
    return b;
  endfunction

  function automatic void m_clear();
    for (int i = 0; i < 16; i++) mb[i] = 4'd0;
    m_win = 0; m_lose = 0; m_over = 0;
  endfunction

  function automatic void m_spawn(input logic [15:0] l);
    int idx;
    for (int i = 0; i < 16; i++) begin
      idx = (int'(l[3:0]) + i) % 16;
      if (mb[idx] == 4'd0) begin
        mb[idx] = (l[7:4] == 4'd0) ? 4'd2 : 4'd1;
        return;
      end
    end
  endfunction

  // dir: 0 up, 1 down, 2 left, 3 right
  function automatic void m_move(input int dir);
    int idx [4];
    int vals [$];
    int res [$];
    int i;
    m_changed = 0;
    for (int k = 0; k < 4; k++) begin
      vals.delete();
      res.delete();
      for (int p = 0; p < 4; p++) begin
        case (dir)
          0:       idx[p] = p * 4 + k;
          1:       idx[p] = (3 - p) * 4 + k;
          2:       idx[p] = k * 4 + p;
          default: idx[p] = k * 4 + 3 - p;
        endcase
        if (mb[idx[p]] != 4'd0) vals.push_back(int'(mb[idx[p]]));
      end
      i = 0;
      while (i < vals.size()) begin
        if (i + 1 < vals.size() && vals[i] == vals[i+1]) begin
          res.push_back((vals[i] + 1 > 15) ? 15 : vals[i] + 1);
          i += 2;
        end else begin
          res.push_back(vals[i]);
          i += 1;
        end
      end
      while (res.size() < 4) res.push_back(0);
      for (int p = 0; p < 4; p++) begin
        if (int'(mb[idx[p]]) != res[p]) m_changed = 1;
        mb[idx[p]] = 4'(res[p]);
      end
    end
  endfunction

  function automatic void m_check();
    bit empty = 0, pair = 0;
    m_win = 0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (int'(mb[r*4+c]) >= WIN) m_win = 1;
        if (mb[r*4+c] == 4'd0) empty = 1;
        if (c < 3 && mb[r*4+c] == mb[r*4+c+1]) pair = 1;
        if (r < 3 && mb[r*4+c] == mb[(r+1)*4+c]) pair = 1;
      end
    end
    m_lose = !m_win && !empty && !pair;
    m_over = m_win || m_lose;
  endfunction

  function automatic int pick_dir(input logic [3:0] bits);
    if (bits[3]) return 0;
    if (bits[2]) return 1;
    if (bits[1]) return 2;
    if (bits[0]) return 3;
    return -1;
  endfunction

  // Update the model for a move request issued this cycle; returns expected busy length.
  function automatic int m_expect_move(input logic [3:0] bits);
    logic [15:0] l;
    int d = pick_dir(bits);
    if (m_over || d < 0) return 0;
    l = lfsr_adv(m_lfsr, 5);
    m_move(d);
    if (m_changed) m_spawn(l);
    m_check();
    return 6;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (reset) m_lfsr = lfsr_step(m_lfsr);
  endtask

  task automatic run_move(input logic [3:0] bits, output int nb);
    {mv_up, mv_down, mv_left, mv_right} = bits;
    tick();
    {mv_up, mv_down, mv_left, mv_right} = 4'b0000;
    nb = 0;
    for (int i = 0; i < 12; i++) begin
      if (!busy) break;
      nb++;
      tick();
    end
  endtask

  task automatic run_load(input board_t img);
    load_states = img;
    load = 1'b1;
    tick();
    load = 1'b0;
    load_states = '0;
    for (int i = 0; i < 16; i++) mb[i] = img[i];
    tick();
    m_check();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    m_clear();
    m_lfsr = SEED;
    tick(); tick();
    n_cmp++; if (states !== '0) begin n_bad++; $display("FAIL reset_states: got %h expected 0", states); end
    n_cmp++; if (win !== 1'b0) begin n_bad++; $display("FAIL reset_win: got %b expected 0", win); end
    n_cmp++; if (lose !== 1'b0) begin n_bad++; $display("FAIL reset_lose: got %b expected 0", lose); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL reset_busy: got %b expected 1", busy); end
    reset = 1'b1;
    m_spawn(m_lfsr);
    tick();
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL init_busy: got %b expected 1", busy); end
    m_spawn(m_lfsr);
    tick();
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL init_done_busy: got %b expected 0", busy); end
    n_cmp++; if (states !== pack_model()) begin n_bad++; $display("FAIL init_board: got %h expected %h", states, pack_model()); end
    begin
      int nz = 0;
      for (int i = 0; i < 16; i++) if (states[i] == 4'd1 || states[i] == 4'd2) nz++; else if (states[i] != 4'd0) nz += 100;
      n_cmp++; if (nz !== 2) begin n_bad++; $display("FAIL init_tile_count: got %0d expected 2", nz); end
    end
  endtask

  task automatic test_merge_left();
    board_t img = '0;
    int nb, eb;
    img[0] = 4'd1; img[1] = 4'd1; img[2] = 4'd1; img[3] = 4'd1;
    run_load(img);
    eb = m_expect_move(4'b0010);
    run_move(4'b0010, nb);
    n_cmp++; if (nb !== 6) begin n_bad++; $display("FAIL left_busy: got %0d expected 6 (model %0d)", nb, eb); end
    n_cmp++; if (states[0] !== 4'd2 || states[1] !== 4'd2) begin n_bad++; $display("FAIL left_row0: got %h expected 2,2", states[1:0]); end
    n_cmp++; if (states !== pack_model()) begin n_bad++; $display("FAIL left_board: got %h expected %h", states, pack_model()); end
  endtask

  task automatic test_merge_right();
    board_t img = '0;
    int nb;
    img[0] = 4'd1; img[1] = 4'd1; img[2] = 4'd2;
    img[4] = 4'd1; img[5] = 4'd2; img[6] = 4'd3; img[7] = 4'd4;
    img[14] = 4'd5; img[15] = 4'd6;
    run_load(img);
    void'(m_expect_move(4'b0001));
    run_move(4'b0001, nb);
    n_cmp++; if (nb !== 6) begin n_bad++; $display("FAIL right_busy: got %0d expected 6", nb); end
    n_cmp++; if (states[3] !== 4'd2 || states[2] !== 4'd2) begin n_bad++; $display("FAIL right_row0: got %h expected 2,2 at cols 3,2", states[3:0]); end
    n_cmp++; if (states !== pack_model()) begin n_bad++; $display("FAIL right_board: got %h expected %h", states, pack_model()); end
  endtask

  task automatic test_no_change();
    board_t img = '0;
    int nb;
    img[0] = 4'd1; img[1] = 4'd2;
    run_load(img);
    run_move(4'b0010, nb);
    n_cmp++; if (nb !== 6) begin n_bad++; $display("FAIL nochg_busy: got %0d expected 6", nb); end
    n_cmp++; if (states !== img) begin n_bad++; $display("FAIL nochg_board: got %h expected %h", states, img); end
    n_cmp++; if ({win, lose} !== 2'b00) begin n_bad++; $display("FAIL nochg_flags: got %b expected 00", {win, lose}); end
  endtask

  task automatic test_win();
    board_t img = '0;
    int nb;
    img[0] = 4'd10; img[1] = 4'd10;
    run_load(img);
    void'(m_expect_move(4'b0010));
    run_move(4'b0010, nb);
    n_cmp++; if (states[0] !== 4'd11) begin n_bad++; $display("FAIL win_cell0: got %0d expected 11", states[0]); end
    n_cmp++; if ({win, lose} !== 2'b10) begin n_bad++; $display("FAIL win_flags: got %b expected 10", {win, lose}); end
    n_cmp++; if (states !== pack_model()) begin n_bad++; $display("FAIL win_board: got %h expected %h", states, pack_model()); end
    run_move(4'b1000, nb);
    n_cmp++; if (nb !== 0) begin n_bad++; $display("FAIL over_busy: got %0d expected 0", nb); end
    n_cmp++; if (states !== pack_model()) begin n_bad++; $display("FAIL over_board: got %h expected %h", states, pack_model()); end
  endtask

  task automatic test_lose_newgame();
    board_t img;
    int nb;
    for (int i = 0; i < 16; i++) img[i] = (((i / 4) + (i % 4)) % 2 != 0) ? 4'd2 : 4'd1;
    run_load(img);
    n_cmp++; if ({win, lose} !== 2'b01) begin n_bad++; $display("FAIL lose_flags: got %b expected 01", {win, lose}); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL lose_busy: got %b expected 0", busy); end
    run_move(4'b1111, nb);
    n_cmp++; if (nb !== 0 || states !== img) begin n_bad++; $display("FAIL lose_ignore: busy %0d board %h expected 0 / %h", nb, states, img); end
    new_game = 1'b1; load = 1'b1; load_states = {16{4'h5}};
    tick();
    new_game = 1'b0; load = 1'b0; load_states = '0;
    m_clear();
    n_cmp++; if (states !== '0 || {win, lose, busy} !== 3'b001) begin n_bad++; $display("FAIL newgame_clear: board %h flags %b expected 0 / 001", states, {win, lose, busy}); end
    m_spawn(m_lfsr);
    tick();
    m_spawn(m_lfsr);
    tick();
    n_cmp++; if (states !== pack_model()) begin n_bad++; $display("FAIL newgame_board: got %h expected %h", states, pack_model()); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL newgame_busy: got %b expected 0", busy); end
  endtask

  task automatic test_priority();
    board_t img = '0;
    int nb;
    logic [3:0] pats [2] = '{4'b1111, 4'b0011};
    for (int t = 0; t < 2; t++) begin
      img = '0;
      img[0] = 4'd1; img[1] = 4'd1; img[4] = 4'd1;
      run_load(img);
      void'(m_expect_move(pats[t]));
      run_move(pats[t], nb);
      n_cmp++; if (states !== pack_model()) begin n_bad++; $display("FAIL prio_board t=%0d: got %h expected %h", t, states, pack_model()); end
    end
  endtask

  task automatic test_ignore_busy();
    board_t img = '0;
    int nb;
    img[0] = 4'd1; img[1] = 4'd1; img[5] = 4'd2; img[7] = 4'd2;
    run_load(img);
    void'(m_expect_move(4'b0010));
    mv_left = 1'b1;
    tick();
    mv_left = 1'b0;
    nb = 0;
    for (int i = 0; i < 12; i++) begin
      if (!busy) break;
      nb++;
      if (i == 1 || i == 5) begin
        mv_up = 1'b1; new_game = 1'b1; load = 1'b1; load_states = {16{4'h5}};
      end
      tick();
      mv_up = 1'b0; new_game = 1'b0; load = 1'b0; load_states = '0;
    end
    n_cmp++; if (nb !== 6) begin n_bad++; $display("FAIL ignore_busy_len: got %0d expected 6", nb); end
    n_cmp++; if (states !== pack_model()) begin n_bad++; $display("FAIL ignore_board: got %h expected %h", states, pack_model()); end
    tick();
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL ignore_no_queue: got %b expected 0", busy); end
  endtask

  task automatic test_reset_mid_move();
    board_t img = '0;
    img[0] = 4'd3; img[1] = 4'd3; img[9] = 4'd4;
    run_load(img);
    mv_right = 1'b1;
    tick();
    mv_right = 1'b0;
    tick();
    #2 reset = 1'b0;
    #1;
    m_clear();
    m_lfsr = SEED;
    n_cmp++; if (states !== '0 || busy !== 1'b1) begin n_bad++; $display("FAIL midreset: board %h busy %b expected 0 / 1", states, busy); end
    tick(); tick();
    reset = 1'b1;
    m_spawn(m_lfsr);
    tick();
    m_spawn(m_lfsr);
    tick();
    n_cmp++; if (states !== pack_model() || busy !== 1'b0) begin n_bad++; $display("FAIL midreset_init: board %h busy %b expected %h / 0", states, busy, pack_model()); end
  endtask

  task automatic test_random();
    board_t img;
    logic [3:0] bits;
    int nb, eb;
    for (int it = 0; it < 10; it++) begin
      for (int i = 0; i < 16; i++) img[i] = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(1, 3)) : 4'd0;
      run_load(img);
      for (int m = 0; m < 4; m++) begin
        bits = 4'($urandom_range(1, 15));
        eb = m_expect_move(bits);
        run_move(bits, nb);
        n_cmp++; if (nb !== eb) begin n_bad++; $display("FAIL rand_busy it=%0d m=%0d: got %0d expected %0d", it, m, nb, eb); end
        n_cmp++; if (states !== pack_model()) begin n_bad++; $display("FAIL rand_board it=%0d m=%0d: got %h expected %h", it, m, states, pack_model()); end
        n_cmp++; if ({win, lose} !== {m_win, m_lose}) begin n_bad++; $display("FAIL rand_flags it=%0d m=%0d: got %b expected %b", it, m, {win, lose}, {m_win, m_lose}); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_merge_left();
    test_merge_right();
    test_no_change();
    test_win();
    test_lose_newgame();
    test_priority();
    test_ignore_busy();
    test_reset_mid_move();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/game_ctrl.md
GAME_CTRL -- requirements
Module: game_ctrl

Interface
REQ-001 Parameter WIN_EXP, default 11: tile exponent that wins the game (11 = 2048).
REQ-002 Parameter LFSR_SEED, default 16'hACE1: LFSR reset value (must be nonzero).
REQ-003 clk  input  1  single system clock; all logic on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 mv_up, mv_down, mv_left, mv_right  input  1 each  one-cycle move request pulses.
REQ-006 new_game  input  1  pulse: clear board and restart.
REQ-007 load  input  1  pulse: overwrite board with load_states (test/debug).
REQ-008 load_states  input  [15:0][3:0]  board image for load.
REQ-009 states  output  [15:0][3:0]  board; cell index r*4+c, row 0 top, col 0 left; value 0 = empty, n = tile 2^n; feeds the screen painter.
REQ-010 win, lose  output  1 each  game-over flags to the painter.
REQ-011 busy  output  1  high whenever FSM is not IDLE or OVER.

Function
REQ-012 FSM states: INIT, IDLE, MOVE, SPAWN, CHECK, OVER.
REQ-013 INIT lasts 2 cycles, spawning one tile per cycle, then goes to IDLE.
REQ-014 In IDLE, a move pulse is accepted; simultaneous pulses resolve by priority up > down > left > right; pulses outside IDLE are ignored, not queued.
REQ-015 MOVE lasts exactly 4 cycles; cycle k processes line k (column k for up/down, row k for left/right) and writes it back at the end of that cycle.
REQ-016 Line order is toward the move direction first: left = col 0..3, right = col 3..0, up = row 0..3, down = row 3..0.
REQ-017 Merge: compress nonzero cells toward position 0; merge equal adjacent pairs scanning from position 0; each tile merges at most once per move; result = exponent+1, saturating at 15.
REQ-018 A sticky changed flag records whether any line differs after merge.
REQ-019 SPAWN (1 cycle): if changed, write one tile into the first empty cell found scanning upward from index lfsr[3:0] with wrap 15->0; value is 2 when lfsr[7:4]==0, else 1; if not changed, no write.
REQ-020 CHECK (1 cycle): win = any cell >= WIN_EXP; lose = no empty cell AND no horizontally or vertically adjacent equal pair; win takes precedence (lose forced 0 when win).
REQ-021 From CHECK: go to OVER if win or lose, else IDLE.
REQ-022 OVER holds board and flags; only new_game, load or reset leave it.
REQ-023 Timing: move pulse sampled at edge T -> MOVE covers T+1..T+4, SPAWN T+5, CHECK T+6, IDLE at T+7 with final states, win and lose; busy high for exactly 6 cycles.
REQ-024 16-bit Fibonacci LFSR (taps 16,14,13,11) advances every cycle in all states.
REQ-025 new_game (IDLE or OVER): clear all cells, win and lose, then go to INIT.
REQ-026 load (IDLE or OVER): copy load_states, clear win and lose, then go to CHECK.
REQ-027 new_game and load asserted together: new_game wins.
REQ-028 Both new_game and load are ignored in INIT, MOVE, SPAWN and CHECK.

Reset
REQ-029 reset low: states all 0, win 0, lose 0, LFSR = LFSR_SEED, changed 0, FSM = INIT, so busy reads 1.
REQ-030 Reset asserted mid-move aborts the move immediately; no partial line is preserved.

Structure
REQ-031 Shared package game_pkg holds the FSM state enum, direction enum, cell type (4-bit exponent), board type ([15:0][3:0]) and the WIN_EXP default.
REQ-032 One combinational sub-module, line_merge: 4 x 4-bit line in, 4 x 4-bit merged line out, plus a changed bit; instantiated once and time-shared across the 4 MOVE cycles.

Verification
REQ-033 Release reset -> after 2 cycles exactly two cells nonzero, each 1 or 2; busy low from cycle 3.
REQ-034 load row0 = {1,1,1,1}, rest 0; mv_left -> row0 = {2,2,0,0} plus exactly one new tile (1 or 2) in an empty cell; busy high 6 cycles.
REQ-035 load row0 = {1,1,2,0}; mv_right -> row0 = {0,0,2,2} except at most one spawned cell; other rows unchanged apart from that spawn.
REQ-036 load row0 = {1,2,0,0}, rest 0; mv_left -> board bit-identical, no spawn, win = lose = 0.
REQ-037 load row0 = {10,10,0,0}; mv_left -> cell 0 = 11, win = 1, FSM in OVER; a later mv_up leaves the board unchanged.
REQ-038 load full board alternating 1/2 checkerboard -> lose = 1 at CHECK+1; mv_* ignored; new_game -> flags clear and INIT respawns 2 tiles.
